// File: rtl/posit_round_encode.sv
// Posit final stage: regime/exponent/fraction packing, rounding, sign, saturation.
// Define POSIT_RNE_EN for round-to-nearest-even; otherwise the magnitude is truncated.
module posit_round_encode #(
  parameter int unsigned N  = 8,
  parameter int unsigned Bs = $clog2(N),
  parameter int unsigned es = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               sign_in,
  input  logic               zf_in,
  input  logic [Bs+es:0]     e_normal,
  input  logic [N-es+1:0]    m_normal,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       posit_out,
  output logic               sat_out
);

  localparam int unsigned TW   = N + 1;
  localparam int unsigned W    = 2*N + 2;
  localparam int          RMAX = int'(N) - 1;
  localparam int          RMIN = -int'(N);
`ifdef POSIT_RNE_EN
  localparam int unsigned SW = W;
`else
  localparam int unsigned SW = N;
`endif

  localparam logic [W-1:0] ALL1   = '1;
  localparam logic [W-1:0] TOP1   = {1'b1, {(W-1){1'b0}}};
  localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINPOS = {{(N-1){1'b0}}, 1'b1};

  // ---------------- stage 1: regime decode and string build ----------------
  int           k;
  int unsigned  run_len;
  logic         run_bit;
  logic [W-1:0] tail_w;
  logic [SW-1:0] str;
  logic         sat_hi;
  logic         sat_lo;

  always_comb begin
    k       = int'(e_normal[Bs+es:es]) - (1 << Bs);
    run_bit = (k >= 0);
    run_len = run_bit ? unsigned'(k + 1) : unsigned'(-k);
    if (run_len > N - 1)
      run_len = N - 1;
    sat_hi  = (k >= RMAX);
    sat_lo  = (k <= RMIN);
    // The hidden bit sits above the tail and falls off in the cast: posits encode it implicitly.
    tail_w  = W'({m_normal[N-es+1], e_normal[es-1:0], m_normal[N-es:0], {(W-TW){1'b0}}});
    // Sign slot (0), regime run, terminator, then the tail; only the top SW bits are kept.
    str     = SW'(((tail_w >> (run_len + 2)) |
                   (run_bit ? (~(ALL1 >> run_len) >> 1) : (TOP1 >> (run_len + 1)))) >> (W - SW));
  end

  logic         s1_v;
  logic         s1_sign;
  logic         s1_zf;
  logic         s1_sat_hi;
  logic         s1_sat_lo;
  logic [N-1:0] s1_kept;
`ifdef POSIT_RNE_EN
  logic         s1_guard;
  logic         s1_sticky;
`endif

  logic s1_en;
  logic s2_en;
  logic s2_v;

  assign s2_en     = ~s2_v | out_ready;
  assign s1_en     = ~s1_v | s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_sign   <= 1'b0;
      s1_zf     <= 1'b0;
      s1_sat_hi <= 1'b0;
      s1_sat_lo <= 1'b0;
      s1_kept   <= '0;
`ifdef POSIT_RNE_EN
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
`endif
    end else if (s1_en) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_sign   <= sign_in;
        s1_zf     <= zf_in;
        s1_sat_hi <= sat_hi;
        s1_sat_lo <= sat_lo;
        s1_kept   <= str[SW-1 -: N];
`ifdef POSIT_RNE_EN
        s1_guard  <= str[SW-1-N];
        s1_sticky <= |str[SW-2-N:0];
`endif
      end
    end
  end

  // ---------------- stage 2: round, saturate, negate ----------------
  logic         round_up;
  logic [N:0]   sum;
  logic [N-1:0] mag;
  logic         sat_n;
  logic [N-1:0] posit_n;

  always_comb begin
`ifdef POSIT_RNE_EN
    round_up = s1_guard & (s1_sticky | s1_kept[0]);
`else
    round_up = 1'b0;
`endif
    sum   = {1'b0, s1_kept} + {{N{1'b0}}, round_up};
    mag   = sum[N-1:0];
    sat_n = 1'b0;
    if (s1_zf) begin
      mag = '0;
    end else if (s1_sat_hi || sum[N] || sum[N-1]) begin
      mag   = MAXPOS;
      sat_n = 1'b1;
    end else if (s1_sat_lo || (sum == '0)) begin
      mag   = MINPOS;
      sat_n = 1'b1;
    end
    posit_n = s1_sign ? (~mag + 1'b1) : mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v      <= 1'b0;
      posit_out <= '0;
      sat_out   <= 1'b0;
    end else if (s2_en) begin
      s2_v <= s1_v;
      if (s1_v) begin
        posit_out <= posit_n;
        sat_out   <= sat_n;
      end
    end
  end

endmodule

// File: tb/tb_posit_round_encode.sv
// Directed bench for posit_round_encode (N=8, es=4, Bs=3): vector table plus stall and reset sequences.
module tb_posit_round_encode;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       sign_in = 1'b0;
  logic       zf_in = 1'b0;
  logic [7:0] e_normal = '0;
  logic [5:0] m_normal = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] posit_out;
  logic       sat_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  posit_round_encode #(.N(8), .Bs(3), .es(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .zf_in     (zf_in),
    .e_normal  (e_normal),
    .m_normal  (m_normal),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .posit_out (posit_out),
    .sat_out   (sat_out)
  );

  typedef struct {
    string      name;
    logic       sign;
    logic       zf;
    logic [7:0] e;
    logic [5:0] m;
    logic [7:0] posit;
    logic       sat;
  } vec_t;

  localparam int NV = 19;
  vec_t vec [NV];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    sign_in  = v.sign;
    zf_in    = v.zf;
    e_normal = v.e;
    m_normal = v.m;
  endtask

  task automatic apply_one(input vec_t v);
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check1({v.name, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check1({v.name, "_valid_lat1"}, out_valid, 1'b0);
    @(posedge clk); #1;
    check1({v.name, "_valid_lat2"}, out_valid, 1'b1);
    check8({v.name, "_posit"}, posit_out, v.posit);
    check1({v.name, "_sat"}, sat_out, v.sat);
  endtask

  task automatic stall_burst();
    int idx [5] = '{9, 10, 11, 0, 1};
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic [7:0] held = '0;
    logic held_v = 1'b0;
    while (got < 5 && cyc < 60) begin
      out_ready = (cyc >= 6);
      if (sent < 5) begin
        drive(vec[idx[sent]]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc >= 2 && cyc <= 5)
        check1("stall_in_ready_low", in_ready, 1'b0);
      if (out_valid && !out_ready) begin
        if (held_v)
          check8("stall_hold", posit_out, held);
        held   = posit_out;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        check8("burst_order", posit_out, vec[idx[got]].posit);
        got++;
      end
      if (in_valid && in_ready)
        sent++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 5) begin
      failures++;
      $display("FAIL burst_timeout actual=%0d expected=5", got);
    end
  endtask

  initial begin
    vec[0]  = '{"pos_one",    1'b0, 1'b0, 8'h80, 6'h20, 8'h40, 1'b0};
    vec[1]  = '{"neg_one",    1'b1, 1'b0, 8'h80, 6'h20, 8'hC0, 1'b0};
    vec[2]  = '{"zero",       1'b1, 1'b1, 8'hFF, 6'h3F, 8'h00, 1'b0};
    vec[3]  = '{"maxpos",     1'b0, 1'b0, 8'hFF, 6'h20, 8'h7F, 1'b1};
    vec[4]  = '{"neg_maxpos", 1'b1, 1'b0, 8'hFF, 6'h20, 8'h81, 1'b1};
    vec[5]  = '{"minpos",     1'b0, 1'b0, 8'h00, 6'h20, 8'h01, 1'b1};
    vec[6]  = '{"neg_minpos", 1'b1, 1'b0, 8'h00, 6'h20, 8'hFF, 1'b1};
    vec[8]  = '{"tie_even",   1'b0, 1'b0, 8'h80, 6'h28, 8'h40, 1'b0};
    vec[9]  = '{"k_pos1",     1'b0, 1'b0, 8'h90, 6'h20, 8'h60, 1'b0};
    vec[10] = '{"k_neg1",     1'b0, 1'b0, 8'h70, 6'h20, 8'h20, 1'b0};
    vec[11] = '{"exp5",       1'b0, 1'b0, 8'h85, 6'h20, 8'h4A, 1'b0};
    vec[12] = '{"k_m7_exact", 1'b0, 1'b0, 8'h10, 6'h20, 8'h01, 1'b1};
    vec[14] = '{"k_6",        1'b0, 1'b0, 8'hE0, 6'h20, 8'h7F, 1'b0};
    vec[15] = '{"k_m6",       1'b0, 1'b0, 8'h20, 6'h20, 8'h01, 1'b0};
`ifdef POSIT_RNE_EN
    vec[7]  = '{"tie_odd",    1'b0, 1'b0, 8'h80, 6'h38, 8'h42, 1'b0};
    vec[13] = '{"k_m7_stky",  1'b0, 1'b0, 8'h11, 6'h20, 8'h01, 1'b0};
    vec[16] = '{"above_tie",  1'b0, 1'b0, 8'h80, 6'h29, 8'h41, 1'b0};
    vec[17] = '{"neg_tie",    1'b1, 1'b0, 8'h80, 6'h38, 8'hBE, 1'b0};
    vec[18] = '{"carry_reg",  1'b0, 1'b0, 8'h8F, 6'h38, 8'h60, 1'b0};
`else
    vec[7]  = '{"tie_odd",    1'b0, 1'b0, 8'h80, 6'h38, 8'h41, 1'b0};
    vec[13] = '{"k_m7_stky",  1'b0, 1'b0, 8'h11, 6'h20, 8'h01, 1'b1};
    vec[16] = '{"above_tie",  1'b0, 1'b0, 8'h80, 6'h29, 8'h40, 1'b0};
    vec[17] = '{"neg_tie",    1'b1, 1'b0, 8'h80, 6'h38, 8'hBF, 1'b0};
    vec[18] = '{"carry_reg",  1'b0, 1'b0, 8'h8F, 6'h38, 8'h5F, 1'b0};
`endif

    repeat (2) @(posedge clk);
    #1;
    check1("rst_out_valid", out_valid, 1'b0);
    check8("rst_posit", posit_out, 8'h00);
    check1("rst_sat", sat_out, 1'b0);
    check1("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++)
      apply_one(vec[i]);

    @(posedge clk); #1;
    stall_burst();

    // two beats in flight, then reset mid-cycle
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(vec[i]);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check1("inflight_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check1("mid_rst_out_valid", out_valid, 1'b0);
    check8("mid_rst_posit", posit_out, 8'h00);
    check1("mid_rst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check1("post_rst_no_stale", out_valid, 1'b0);
      check1("post_rst_in_ready", in_ready, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
